fnd_scan_decoder: RTL
=====================

Name: fnd_scan_decoder

Overview:
- Receive-side counterpart of the FND scan driver used by the up/down counter top.
- Watches the multiplexed 4-digit 7-segment bus (fndCom/fndFont) and debounces each digit slot.
- Decodes segment patterns back to BCD and assembles complete frames into a BCD word plus a binary value.
- Used as an on-chip self-check monitor and as the bench-side scoreboard front end for counter tops.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples (same fndCom, same fndFont) required before a digit is captured; legal range 1..255.
- TIMEOUT_CYCLES, 1_000_000: cycles without any digit capture before the stall flag sets; legal range 2..2^24-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- fndCom  in  4  digit enables, active-low one-hot; 1110=digit0 (ones), 1101=digit1, 1011=digit2, 0111=digit3
- fndFont  in  8  segments, active-low, {dp,g,f,e,d,c,b,a}
- bcd  out  16  last complete frame, {d3,d2,d1,d0}, 4 bits per digit
- value  out  14  binary value of bcd: d3*1000 + d2*100 + d1*10 + d0
- dp  out  4  decimal-point state per digit of the last frame; 1 = lit
- frame_valid  out  1  one-cycle pulse when bcd/value/dp update
- seg_error  out  1  sticky; set on an undecodable segment pattern
- stall  out  1  level; high while the timeout has expired

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): bcd=0, value=0, dp=0, frame_valid=0, seg_error=0, stall=0.
  - Also clears the capture mask, stability counter and timeout counter, and sets the FSM to IDLE.
  - Reset mid-frame discards partial digits.
- Input stage: fndCom and fndFont are registered once (com_q, font_q). All logic uses the registered copies plus the previous sample (com_p, font_p).
- com_q is valid only if it is exactly one of the four one-hot-low codes. 1111 (blanking) and multi-low codes are invalid.
- Decode table (font_q[6:0] to digit): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - Any other pattern maps to digit F and sets seg_error, but only when that digit is captured.
  - dp bit = ~font_q[7].
- FSM, states IDLE, SETTLE, HELD:
  - IDLE: com_q valid → SETTLE, cnt=1.
  - SETTLE: com_q valid and (com_q,font_q)==(com_p,font_p) → cnt++.
    - Change to a different valid pair → restart with cnt=1.
    - com_q invalid → IDLE.
    - When cnt reaches STABLE_CYCLES → capture: write the digit slot, set its mask bit, clear the timeout counter, go to HELD.
    - STABLE_CYCLES=1 captures on the first valid sample.
  - HELD: stays while the pair is unchanged; no recapture.
    - Pair change to a valid pair → SETTLE, cnt=1.
    - com_q invalid → IDLE.
- Frame assembly:
  - When a capture makes the mask 1111, in the next cycle bcd/dp/value load from the slots, frame_valid pulses for 1 cycle, and the mask clears.
  - A digit recaptured before the mask completes overwrites its slot; the mask is unchanged.
  - Latency from the first fndCom/fndFont edge of the completing digit to frame_valid: STABLE_CYCLES + 2 cycles.
- value: computed combinationally from the slots and registered with bcd. Digits of F contribute 15×weight, with no saturation; seg_error flags this case.
- Timeout:
  - The counter increments every cycle with no capture.
  - When it equals TIMEOUT_CYCLES-1 and no capture occurs, stall sets and the counter holds.
  - Any capture clears both the counter and stall in the same cycle.
- Simultaneous events: a capture on the cycle the timeout would expire wins, so stall stays 0.
- Outputs hold their values between frames.

Decomposition:
- Package fnd_pkg:
  - digit-enable code constants COM_D0..COM_D3 and COM_BLANK;
  - segment pattern constants SEG_0..SEG_9;
  - FSM state enum fnd_dec_state_t;
  - function seg_to_bcd (7-bit pattern → 4-bit digit + error flag).
  - The existing FND driver is to be switched to these same constants.
- One sub-module: fnd_digit_settle. It holds the input registers, the stability counter and the FSM, and outputs capture_stb, digit_idx[1:0], digit[3:0], dp_bit and bad_seg.
- The top holds the mask, the slots, bcd-to-binary conversion and the timeout.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random inputs → all outputs 0, no frame_valid.
- Clean frame, STABLE_CYCLES=4:
  - Stimulus: hold each code for 10 cycles; 1110/F9, 1101/A4, 1011/B0, 0111/99.
  - Response: a single frame_valid; bcd=16'h4321, value=4321, dp=0000.
- Glitch rejection: within digit0, drive fndFont=A4 for 2 cycles, then F9 for 10 cycles → d0 captured as 1, never 2.
- Blanking and bad pattern:
  - Insert 1111 for 3 cycles between digits; frame still completes.
  - Digit2 font 8'hFF → d2=F, seg_error=1 sticky until rst.
- Timeout, TIMEOUT_CYCLES=50:
  - Hold fndCom=1111 → stall=1 at cycle 50 after the last capture.
  - The next capture drops stall in the same cycle.
- Full counter top, mode=0, counting up:
  - Each frame_valid value is previous+1 mod 10000.
  - Mid-frame rst pulse → no frame_valid until four fresh digits are captured.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment (FND) bus.
package fnd_pkg;

  // Digit enables, active-low one-hot; digit0 is the ones digit.
  localparam logic [3:0] COM_D0    = 4'b1110;
  localparam logic [3:0] COM_D1    = 4'b1101;
  localparam logic [3:0] COM_D2    = 4'b1011;
  localparam logic [3:0] COM_D3    = 4'b0111;
  localparam logic [3:0] COM_BLANK = 4'b1111;

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } fnd_dec_state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } seg_dec_t;

  // Unknown patterns decode to F so a bad digit stays visible in the frame.
  function automatic seg_dec_t seg_to_bcd(input logic [6:0] seg);
    seg_dec_t r;
    r.err   = 1'b0;
    r.digit = 4'd0;
    case (seg)
      SEG_0:   r.digit = 4'd0;
      SEG_1:   r.digit = 4'd1;
      SEG_2:   r.digit = 4'd2;
      SEG_3:   r.digit = 4'd3;
      SEG_4:   r.digit = 4'd4;
      SEG_5:   r.digit = 4'd5;
      SEG_6:   r.digit = 4'd6;
      SEG_7:   r.digit = 4'd7;
      SEG_8:   r.digit = 4'd8;
      SEG_9:   r.digit = 4'd9;
      default: begin
        r.digit = 4'hF;
        r.err   = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fnd_scan_decoder_settle.sv
// Per-slot debounce: registers the bus, waits for a stable (com,font) pair
// and emits one capture strobe per stable pair.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | bus blanked or invalid digit enable; nothing counting
// ST_SETTLE | valid pair seen, counting consecutive identical samples
// ST_HELD   | pair captured; waiting for it to change (no recapture)
module fnd_digit_settle
  import fnd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] com,
  input  logic [7:0] font,
  output logic       capture_stb,
  output logic [1:0] digit_idx,
  output logic [3:0] digit,
  output logic       dp_bit,
  output logic       bad_seg
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  fnd_dec_state_t state, state_nx;
  logic [3:0] com_q, com_p;
  logic [7:0] font_q, font_p;
  logic [7:0] cnt, cnt_nx, cnt_run;
  logic       com_ok, same;
  seg_dec_t   dec;

  // Input stage, previous-sample copy and FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      com_q  <= COM_BLANK;
      font_q <= 8'hFF;
      com_p  <= COM_BLANK;
      font_p <= 8'hFF;
      state  <= ST_IDLE;
      cnt    <= 8'd0;
    end else begin
      com_q  <= com;
      font_q <= font;
      com_p  <= com_q;
      font_p <= font_q;
      state  <= state_nx;
      cnt    <= cnt_nx;
    end
  end

  // Next-state, stability count and capture decision.
  always_comb begin
    com_ok = (com_q == COM_D0) || (com_q == COM_D1) ||
             (com_q == COM_D2) || (com_q == COM_D3);
    same   = (com_q == com_p) && (font_q == font_p);
    // Any sample that does not continue a settling run starts a new one at 1.
    cnt_run     = (state == ST_SETTLE && same) ? cnt + 8'd1 : 8'd1;
    state_nx    = state;
    cnt_nx      = cnt;
    capture_stb = 1'b0;
    case (state)
      ST_IDLE, ST_SETTLE: begin
        if (!com_ok) begin
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt_run;
          if (cnt_run == STABLE_N) begin
            capture_stb = 1'b1;
            state_nx    = ST_HELD;
          end else begin
            state_nx = ST_SETTLE;
          end
        end
      end
      ST_HELD: begin
        if (!com_ok) begin
          state_nx = ST_IDLE;
        end else if (!same) begin
          cnt_nx = cnt_run;
          if (cnt_run == STABLE_N) begin
            capture_stb = 1'b1;
            state_nx    = ST_HELD;
          end else begin
            state_nx = ST_SETTLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Decode of the currently registered sample.
  always_comb begin
    dec     = seg_to_bcd(font_q[6:0]);
    digit   = dec.digit;
    bad_seg = dec.err;
    dp_bit  = ~font_q[7];
    case (com_q)
      COM_D1:  digit_idx = 2'd1;
      COM_D2:  digit_idx = 2'd2;
      COM_D3:  digit_idx = 2'd3;
      default: digit_idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Receive-side FND monitor: assembles debounced digits into frames,
// converts the frame to binary and flags stalls and bad patterns.
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fndCom,
  input  logic [7:0]  fndFont,
  output logic [15:0] bcd,
  output logic [13:0] value,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        seg_error,
  output logic        stall
);

  localparam logic [23:0] TMO_LOAD = 24'(TIMEOUT_CYCLES - 1);

  logic        capture_stb, dp_bit, bad_seg;
  logic [1:0]  digit_idx;
  logic [3:0]  digit;
  logic [3:0]  mask, mask_base;
  logic [3:0]  slot [4];
  logic [3:0]  slot_dp;
  logic [13:0] value_nx;
  logic [23:0] tmr;

  fnd_digit_settle #(.STABLE_CYCLES(STABLE_CYCLES)) u_settle (
    .clk         (clk),
    .rst         (rst),
    .com         (fndCom),
    .font        (fndFont),
    .capture_stb (capture_stb),
    .digit_idx   (digit_idx),
    .digit       (digit),
    .dp_bit      (dp_bit),
    .bad_seg     (bad_seg)
  );

  // Binary value of the slots; F digits weigh 15 and simply wrap at 14 bits.
  always_comb begin
    value_nx = 14'(slot[3]) * 14'd1000 + 14'(slot[2]) * 14'd100 +
               14'(slot[1]) * 14'd10   + 14'(slot[0]);
    mask_base = (mask == 4'hF) ? 4'h0 : mask;
  end

  // Digit slots and capture mask; a full mask is consumed the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask    <= 4'h0;
      slot_dp <= 4'h0;
      for (int i = 0; i < 4; i++) slot[i] <= 4'h0;
    end else begin
      mask <= mask_base;
      if (capture_stb) begin
        slot[digit_idx]    <= digit;
        slot_dp[digit_idx] <= dp_bit;
        mask               <= mask_base | (4'b0001 << digit_idx);
      end
    end
  end

  // Frame outputs and sticky segment error.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd         <= 16'h0;
      value       <= 14'd0;
      dp          <= 4'h0;
      frame_valid <= 1'b0;
      seg_error   <= 1'b0;
    end else begin
      frame_valid <= (mask == 4'hF);
      if (mask == 4'hF) begin
        bcd   <= {slot[3], slot[2], slot[1], slot[0]};
        value <= value_nx;
        dp    <= slot_dp;
      end
      if (capture_stb && bad_seg) seg_error <= 1'b1;
    end
  end

  // Stall timer: down-counter reloaded by every capture; capture beats expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr   <= TMO_LOAD;
      stall <= 1'b0;
    end else if (capture_stb) begin
      tmr   <= TMO_LOAD;
      stall <= 1'b0;
    end else if (tmr == 24'd0) begin
      stall <= 1'b1;
    end else begin
      tmr <= tmr - 24'd1;
    end
  end

endmodule
